// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost flags and any depth >= 2.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_param #(
  parameter int FIFO_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic [FIFO_WIDTH-1:0]              data_in,
  output logic [FIFO_WIDTH-1:0]              data_out,
  output logic                               wr_ack,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               full,
  output logic                               empty,
  output logic                               almostfull,
  output logic                               almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_param: FIFO_DEPTH must be >= 2");
  end
  if (AEMPTY_LEVEL >= AFULL_LEVEL) begin : g_bad_levels
    $fatal(1, "fifo_param: AEMPTY_LEVEL must be below AFULL_LEVEL");
  end
  if (AFULL_LEVEL > FIFO_DEPTH) begin : g_bad_afull
    $fatal(1, "fifo_param: AFULL_LEVEL must not exceed FIFO_DEPTH");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CNT_W'(AFULL_LEVEL)) && !full;
  assign almostempty = (count <= CNT_W'(AEMPTY_LEVEL)) && !empty;

  // A full FIFO still accepts a read and an empty one still accepts a write,
  // so simultaneous requests resolve purely from the current occupancy.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_out <= '0;
    else if (rd_ok) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a default 8-deep instance and a 5-deep instance
// with custom almost thresholds, both checked against a queue-based model.
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we8 = 1'b0, re8 = 1'b0, we5 = 1'b0, re5 = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout8, dout5;
  logic        ack8, ovf8, udf8, full8, empty8, af8, ae8;
  logic        ack5, ovf5, udf5, full5, empty5, af5, ae5;
  logic [3:0]  cnt8;
  logic [2:0]  cnt5;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] q8[$];
  logic [15:0] q5[$];
  logic [15:0] last8 = '0, last5 = '0;

  always #5 clk = ~clk;

  fifo_param dut (
    .clk(clk), .rst_n(rst_n), .wr_en(we8), .rd_en(re8), .data_in(din),
    .data_out(dout8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8),
    .full(full8), .empty(empty8), .almostfull(af8), .almostempty(ae8), .count(cnt8)
  );

  fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AFULL_LEVEL(3), .AEMPTY_LEVEL(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(we5), .rd_en(re5), .data_in(din),
    .data_out(dout5), .wr_ack(ack5), .overflow(ovf5), .underflow(udf5),
    .full(full5), .empty(empty5), .almostfull(af5), .almostempty(ae5), .count(cnt5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    q8.delete();
    q5.delete();
    last8 = '0;
    last5 = '0;
  endtask

  // One clock of stimulus on instance s (0: depth 8, 1: depth 5), then check everything.
  task automatic step(input int s, input bit we, input bit re, input logic [15:0] d);
    int          dep, afl, ael, n;
    bit          wok, rok;
    string       p;
    logic [15:0] exp_d, front;
    dep = (s != 0) ? 5 : 8;
    afl = (s != 0) ? 3 : 7;
    ael = (s != 0) ? 2 : 1;
    p   = (s != 0) ? "d5" : "d8";
    n   = (s != 0) ? q5.size() : q8.size();
    wok = we && (n < dep);
    rok = re && (n > 0);
    din = d;
    if (s == 0) begin we8 = we; re8 = re; end
    else        begin we5 = we; re5 = re; end
    @(posedge clk);
    #1;
    we8 = 1'b0; re8 = 1'b0; we5 = 1'b0; re5 = 1'b0;
    if (s == 0) begin
      if (rok) last8 = q8.pop_front();
      if (wok) q8.push_back(d);
      n = q8.size();
      front = (n > 0) ? q8[0] : '0;
      exp_d = last8;
    end else begin
      if (rok) last5 = q5.pop_front();
      if (wok) q5.push_back(d);
      n = q5.size();
      front = (n > 0) ? q5[0] : '0;
      exp_d = last5;
    end
`ifdef FIFO_FWFT_EN
    exp_d = front;
`endif
    if (s == 0) begin
      check({p, " wr_ack"},      32'(ack8),   32'(wok));
      check({p, " overflow"},    32'(ovf8),   32'(we && !wok));
      check({p, " underflow"},   32'(udf8),   32'(re && !rok));
      check({p, " count"},       32'(cnt8),   32'(n));
      check({p, " full"},        32'(full8),  32'(n == dep));
      check({p, " empty"},       32'(empty8), 32'(n == 0));
      check({p, " almostfull"},  32'(af8),    32'(n >= afl && n != dep));
      check({p, " almostempty"}, 32'(ae8),    32'(n <= ael && n != 0));
      check({p, " data_out"},    32'(dout8),  32'(exp_d));
    end else begin
      check({p, " wr_ack"},      32'(ack5),   32'(wok));
      check({p, " overflow"},    32'(ovf5),   32'(we && !wok));
      check({p, " underflow"},   32'(udf5),   32'(re && !rok));
      check({p, " count"},       32'(cnt5),   32'(n));
      check({p, " full"},        32'(full5),  32'(n == dep));
      check({p, " empty"},       32'(empty5), 32'(n == 0));
      check({p, " almostfull"},  32'(af5),    32'(n >= afl && n != dep));
      check({p, " almostempty"}, 32'(ae5),    32'(n <= ael && n != 0));
      check({p, " data_out"},    32'(dout5),  32'(exp_d));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},       32'(cnt8),   32'd0);
    check({tag, " empty"},       32'(empty8), 32'd1);
    check({tag, " full"},        32'(full8),  32'd0);
    check({tag, " almostfull"},  32'(af8),    32'd0);
    check({tag, " almostempty"}, 32'(ae8),    32'd0);
    check({tag, " wr_ack"},      32'(ack8),   32'd0);
    check({tag, " overflow"},    32'(ovf8),   32'd0);
    check({tag, " underflow"},   32'(udf8),   32'd0);
    check({tag, " data_out"},    32'(dout8),  32'd0);
    check({tag, " d5 count"},    32'(cnt5),   32'd0);
    check({tag, " d5 empty"},    32'(empty5), 32'd1);
  endtask

  initial begin
    #12;
    check_reset_state("reset");
    rst_n = 1'b1;

    step(0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
    step(0, 1, 0, 16'h0009);
    step(0, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0100 + 16'(i));
    step(0, 1, 1, 16'h01FF);
    for (int i = 0; i < 7; i++) step(0, 0, 1, '0);
    step(0, 1, 1, 16'h0200);
    step(0, 0, 1, '0);

    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0300 + 16'(i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, 16'h0400 + 16'(i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0);

    step(0, 1, 0, 16'hABCD);
    step(0, 0, 0, '0);
    step(0, 0, 1, '0);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0500 + 16'(i));
    #2 rst_n = 1'b0;
    #2 check_reset_state("midreset");
    clear_model();
    #2 rst_n = 1'b1;
    step(0, 0, 0, '0);

    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

    for (int i = 0; i < 5; i++) step(1, 1, 0, 16'h0600 + 16'(i));
    step(1, 1, 0, 16'h06FF);
    for (int i = 0; i < 5; i++) step(1, 0, 1, '0);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 16'h0700 + 16'(i));
      if (i % 3 == 2) step(1, 1, 1, 16'h0780 + 16'(i));
      else            step(1, 0, 1, '0);
    end
    for (int i = 0; i < 40; i++)
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

- Parametrised single-clock synchronous FIFO; next generation of the team's FIFO block.
- Generalises width, depth (any depth ≥ 2, not only powers of two) and almost-full/almost-empty thresholds.
- Adds a fill-level output.
- Adds an optional first-word-fall-through (FWFT) read mode selected at compile time.
- Sits between producer and consumer stages in the datapath; drop-in for the previous FIFO when parameters are left at defaults.

## Interface
- FIFO_WIDTH, 16: data word width in bits (≥ 1).
- FIFO_DEPTH, 8: number of storage words (≥ 2).
- AFULL_LEVEL, FIFO_DEPTH-1: count at or above which almostfull asserts (while not full).
- AEMPTY_LEVEL, 1: count at or below which almostempty asserts (while not empty).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  FIFO_WIDTH  write data.
- data_out  output  FIFO_WIDTH  read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected because full.
- underflow  output  1  registered; previous-cycle read rejected because empty.
- full  output  1  combinational from count: count == FIFO_DEPTH.
- empty  output  1  combinational from count: count == 0.
- almostfull  output  1  count ≥ AFULL_LEVEL && !full.
- almostempty  output  1  count ≤ AEMPTY_LEVEL && !empty.
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
- Storage:
  - FIFO_DEPTH × FIFO_WIDTH array.
  - wr_ptr and rd_ptr of width $clog2(FIFO_DEPTH).
  - Each pointer increments and wraps from FIFO_DEPTH-1 to 0 explicitly; no reliance on binary rollover.
  - Memory contents are not reset.
- Write accepted iff wr_en && !full:
  - mem[wr_ptr] <= data_in; wr_ptr advances.
  - Next cycle: wr_ack=1. Otherwise wr_ack=0.
- Write rejected (wr_en && full): no state change; next cycle overflow=1, else overflow=0.
- Read accepted iff rd_en && !empty:
  - Standard mode: data_out <= mem[rd_ptr]; rd_ptr advances.
  - Read rejected (rd_en && empty): data_out holds its value; next cycle underflow=1, else underflow=0.
- Simultaneous wr_en && rd_en:
  - Full: read accepted, write rejected (overflow=1); count drops by 1.
  - Empty: write accepted, read rejected (underflow=1); count rises by 1.
  - Otherwise: both accepted; count unchanged.
- count: +1 on accepted write only, −1 on accepted read only. Never exceeds FIFO_DEPTH; never goes below 0.
- Elaboration check (fatal) on illegal parameters:
  - FIFO_DEPTH < 2.
  - AEMPTY_LEVEL ≥ AFULL_LEVEL.
  - AFULL_LEVEL > FIFO_DEPTH.

## Timing
- Reset (rst_n low, asynchronous):
  - Pointers, count, data_out, wr_ack, overflow and underflow go to 0 immediately.
  - Resulting flags: empty=1, full=0, almostfull=0, almostempty=0.
- Reset asserted mid-operation discards all stored words. Operations resume on the first rising edge after rst_n deasserts.
- Standard-mode read latency: 1 cycle; data visible after the edge that samples rd_en.
- Write-to-read latency: a word written at edge N can be read (rd_en sampled) at edge N+1.
- Flags and count reflect the state after the most recent edge. They are valid in the same cycle, with no extra register stage.

## Configuration
- Macro: FIFO_FWFT_EN.
- Defined (FWFT mode):
  - data_out = empty ? 0 : mem[rd_ptr], combinational.
  - rd_en acts as a pop acknowledging the word already shown.
  - A word written into an empty FIFO at edge N appears on data_out right after edge N.
  - All flag, ack, overflow and underflow rules are unchanged.
- Undefined: standard registered-read mode as specified above.

## Test plan
- Reset then idle (WIDTH=16, DEPTH=8):
  - Required: empty=1, count=0, almostempty=0, all status outputs 0.
  - Assert rst_n low mid-stream with count=5 → count=0 and empty=1 asynchronously, before the next edge.
- Fill 8 words 0x0001..0x0008:
  - wr_ack=1 after each write.
  - almostfull=1 at count=7; full=1 at count=8.
  - A 9th write → overflow=1 for one cycle; count stays 8.
- Drain 8 words → data_out 0x0001..0x0008 in order:
  - almostempty=1 at count=1; empty=1 at count=0.
  - A 9th read → underflow=1; data_out holds 0x0008.
- Simultaneous rd/wr:
  - At count=8: count→7, overflow=1.
  - At count=0: count→1, underflow=1.
  - At count=4 for 20 cycles: count stays 4, data ordered across pointer wrap.
- Non-power-of-two DEPTH=5, AFULL_LEVEL=3, AEMPTY_LEVEL=2:
  - 12 writes/reads interleaved → pointers wrap 4→0, data intact.
  - almostfull at count 3–4; almostempty at count 1–2.
- With FIFO_FWFT_EN:
  - Write 0xABCD into empty FIFO → data_out=0xABCD the cycle after, with no rd_en.
  - rd_en pops it → empty=1, data_out=0.
